mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port SRAM macro between the instruction-fetch requester (IF) and the data-memory requester (DM, load/store from the MEM stage).
- Arbitrates each cycle with DM priority and an IF anti-starvation counter.
- Drives the SRAM control, address and data pins and routes 1-cycle-latency read data back to the owning requester.
- Sits between the pipeline front/back ends and the memory, beside the controller; it consumes the controller's branch-flush so wrong-path fetches are dropped.

Parameters:
- ADDR_W, 14, word address width of the SRAM.
- DATA_W, 32, data width (byte-enable width equals DATA_W, bit-granular).
- STARVE_MAX, 4, consecutive cycles IF may lose to DM before IF is forced to win (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch word address.
- if_flush  in  1  branch/jump taken; kills fetch in flight.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request; held until granted.
- dm_web  in  1  0 = store, 1 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_bweb  in  DATA_W  active-low bit write enables.
- dm_gnt  out  1  data access accepted this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DATA_W  load data.
- mem_ceb  out  1  SRAM chip enable, active low.
- mem_web  out  1  SRAM write enable, active low.
- mem_a  out  ADDR_W  SRAM address.
- mem_di  out  DATA_W  SRAM write data.
- mem_bweb  out  DATA_W  SRAM bit write enables, active low.
- mem_do  in  DATA_W  SRAM read data, valid the cycle after the access.
- stall  out  1  (if_req & ~if_gnt) | (dm_req & ~dm_gnt).

Behaviour:
- Reset values: starve_cnt = 0, rd_owner = NONE. Hence if_rvalid = dm_rvalid = 0 while rst is high, independent of clk.
- Grant (combinational, same cycle as request):
  - if_flush = 1: if_gnt = 0; DM is granted if dm_req.
  - Else, if only one requester is active, it wins.
  - Else, with both active, DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - At most one grant per cycle.
- SRAM drive:
  - Winner present: mem_ceb = 0, and mem_a, mem_web, mem_di, mem_bweb come from the winner.
  - IF access: mem_web = 1, mem_bweb = all 1s.
  - No winner: mem_ceb = 1, mem_web = 1, mem_bweb = all 1s, mem_a/mem_di = 0.
- starve_cnt (posedge):
  - Increments, saturating at STARVE_MAX, when if_req & dm_req & dm_gnt.
  - Clears when if_gnt = 1 or if_req = 0.
  - Holds otherwise, e.g. when IF is blocked by a flush.
- rd_owner (posedge): next = IF if if_gnt, DM if dm_gnt & dm_web, else NONE. Stores never create a response.
- Responses (cycle after grant):
  - if_rvalid = (rd_owner == IF) & ~if_flush. A flush in the response cycle drops the data.
  - dm_rvalid = (rd_owner == DM).
  - if_rdata and dm_rdata both pass mem_do through unmodified; rvalid qualifies the data.
- Fully pipelined: a new grant is allowed in a response cycle, giving 1 access per cycle of throughput and read latency 1.
- Reset mid-operation: a pending response is discarded and the starve history is lost; there is no replay.
- Requester rule (assertion): address and data are stable while req = 1 and gnt = 0.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e.
  - localparams MEM_READ = 1'b1 and MEM_WRITE = 1'b0.
- One sub-module, arb_starve_cnt: a saturating counter with inc/clr inputs and a sat output, parameterised by STARVE_MAX.
- Grant logic and the output mux stay in the top module.

Test Plan:
- IF-only read, if_addr = 0x010, mem_do = 0xDEADBEEF next cycle -> if_gnt = 1 and mem_ceb = 0, mem_web = 1, mem_a = 0x010 in cycle t; if_rvalid = 1, if_rdata = 0xDEADBEEF in t+1; stall = 0.
- Both request continuously, STARVE_MAX = 4 -> dm_gnt in cycles 0–3, if_gnt in cycle 4 (starve_cnt 4 -> 0), dm_gnt in cycle 5; stall = 1 in cycles 0–5.
- DM store, dm_web = 0, dm_bweb = 0xFFFF0000, dm_wdata = 0x12345678, addr 0x020 -> mem_web = 0, mem_bweb = 0xFFFF0000, mem_di = 0x12345678 in t; dm_rvalid = 0 in t+1.
- IF granted in t, if_flush = 1 in t+1 together with if_req and dm_req (load) -> if_rvalid = 0 in t+1, if_gnt = 0 and dm_gnt = 1 in t+1, dm_rvalid = 1 in t+2.
- Back-to-back: DM load in t, IF fetch in t+1 -> dm_rvalid in t+1 and if_rvalid in t+2, each carrying its own mem_do word.
- rst asserted asynchronously mid-cycle during an IF response cycle -> if_rvalid drops to 0 immediately, starve_cnt = 0; after release with both requesters active, DM wins first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM single-port SRAM arbiter.
// Read-response owner encoding and SRAM write-enable polarity.
package mem_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles IF lost to DM; sat forces the next IF win.
// Registered count, combinational sat; clr has priority over inc.
module arb_starve_cnt #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q == CNT_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch (IF) and data (DM): DM priority, IF anti-starvation.
// Same-cycle grant, read data 1 cycle later; losers see gnt=0 and hold their request (stall).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_web,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_bweb,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_ceb,
   output logic              mem_web,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_di,
   output logic [DATA_W-1:0] mem_bweb,
   input  logic [DATA_W-1:0] mem_do,
   output logic              stall
);
   owner_e rd_owner_q;
   owner_e rd_owner_d;
   logic   starve_sat;

   // A flushed fetch is never granted; otherwise IF only beats DM once starved.
   assign if_gnt = if_req & ~if_flush & (~dm_req | starve_sat);
   assign dm_gnt = dm_req & ~if_gnt;
   assign stall  = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

   arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (if_req & dm_req & dm_gnt),
      .clr (if_gnt | ~if_req),
      .sat (starve_sat)
   );

   always_comb begin
      mem_ceb  = 1'b1;
      mem_web  = MEM_READ;
      mem_a    = '0;
      mem_di   = '0;
      mem_bweb = '1;
      if (dm_gnt) begin
         mem_ceb  = 1'b0;
         mem_web  = dm_web;
         mem_a    = dm_addr;
         mem_di   = dm_wdata;
         mem_bweb = dm_bweb;
      end else if (if_gnt) begin
         mem_ceb  = 1'b0;
         mem_a    = if_addr;
      end
   end

   // Stores complete silently, so only reads claim the response slot.
   always_comb begin
      rd_owner_d = OWN_NONE;
      if (if_gnt) begin
         rd_owner_d = OWN_IF;
      end else if (dm_gnt && (dm_web == MEM_READ)) begin
         rd_owner_d = OWN_DM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign if_rvalid = (rd_owner_q == OWN_IF) & ~if_flush;
   assign dm_rvalid = (rd_owner_q == OWN_DM);
   assign if_rdata  = mem_do;
   assign dm_rdata  = mem_do;

   // A flush lets the fetch unit redirect while its request is still pending.
   a_if_hold: assert property (@(posedge clk) disable iff (rst)
      (if_req & ~if_gnt & ~if_flush) |=> $stable(if_addr));
   a_dm_hold: assert property (@(posedge clk) disable iff (rst)
      (dm_req & ~dm_gnt) |=> $stable({dm_web, dm_addr, dm_wdata, dm_bweb}));
   a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(if_gnt && dm_gnt));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus async-reset sequences.
module tb_mem_port_arbiter;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_web = 1'b1;
   logic [13:0] if_addr = '0, dm_addr = '0;
   logic [31:0] dm_wdata = '0, dm_bweb = ONES, mem_do = '0;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_ceb, mem_web, stall;
   logic [31:0] if_rdata, dm_rdata, mem_di, mem_bweb;
   logic [13:0] mem_a;

   int n_chk  = 0;
   int n_pass = 0;

   mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_bweb(dm_bweb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_di(mem_di),
      .mem_bweb(mem_bweb), .mem_do(mem_do), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rq;    // {if_req, if_flush, dm_req, dm_web}
      logic [13:0] ia;
      logic [13:0] da;
      logic [31:0] wd;
      logic [31:0] bw;
      logic [31:0] md;
      logic [5:0]  ex;    // {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_ceb, mem_web}
      logic [13:0] ea;
      logic [31:0] edi;
      logic [31:0] ebw;
      logic        est;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl[NV];

   function automatic vec_t mk(input logic [3:0] rq, input logic [13:0] ia, input logic [13:0] da,
                               input logic [31:0] wd, input logic [31:0] bw, input logic [31:0] md,
                               input logic [5:0] ex, input logic [13:0] ea, input logic [31:0] edi,
                               input logic [31:0] ebw, input logic est);
      vec_t v;
      v.rq = rq; v.ia = ia; v.da = da; v.wd = wd; v.bw = bw; v.md = md;
      v.ex = ex; v.ea = ea; v.edi = edi; v.ebw = ebw; v.est = est;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic ir, input logic [13:0] ia, input logic fl, input logic dr,
                        input logic dw, input logic [13:0] da, input logic [31:0] md);
      if_req = ir; if_addr = ia; if_flush = fl;
      dm_req = dr; dm_web = dw; dm_addr = da; dm_wdata = '0; dm_bweb = ONES;
      mem_do = md;
   endtask

   initial begin
      // cycle-by-cycle stream; the arbiter state carries from row to row
      tbl[0]  = mk(4'b0001, 14'h000, 14'h000, 32'h0, ONES, 32'h0,         6'b000011, 14'h000, 32'h0, ONES, 1'b0);
      tbl[1]  = mk(4'b1001, 14'h010, 14'h000, 32'h0, ONES, 32'h0,         6'b100001, 14'h010, 32'h0, ONES, 1'b0);
      tbl[2]  = mk(4'b0001, 14'h000, 14'h000, 32'h0, ONES, 32'hDEADBEEF,  6'b001011, 14'h000, 32'h0, ONES, 1'b0);
      tbl[3]  = mk(4'b1011, 14'h040, 14'h100, 32'h0, ONES, 32'h0,         6'b010001, 14'h100, 32'h0, ONES, 1'b1);
      tbl[4]  = mk(4'b1011, 14'h040, 14'h100, 32'h0, ONES, 32'hA0A0A0A0,  6'b010101, 14'h100, 32'h0, ONES, 1'b1);
      tbl[5]  = mk(4'b1011, 14'h040, 14'h100, 32'h0, ONES, 32'hA1A1A1A1,  6'b010101, 14'h100, 32'h0, ONES, 1'b1);
      tbl[6]  = mk(4'b1011, 14'h040, 14'h100, 32'h0, ONES, 32'hA2A2A2A2,  6'b010101, 14'h100, 32'h0, ONES, 1'b1);
      tbl[7]  = mk(4'b1011, 14'h040, 14'h100, 32'h0, ONES, 32'hA3A3A3A3,  6'b100101, 14'h040, 32'h0, ONES, 1'b1);
      tbl[8]  = mk(4'b1011, 14'h041, 14'h100, 32'h0, ONES, 32'hB0B0B0B0,  6'b011001, 14'h100, 32'h0, ONES, 1'b1);
      tbl[9]  = mk(4'b1001, 14'h041, 14'h000, 32'h0, ONES, 32'hC0C0C0C0,  6'b100101, 14'h041, 32'h0, ONES, 1'b0);
      tbl[10] = mk(4'b0010, 14'h000, 14'h020, 32'h12345678, 32'hFFFF0000, 32'h11111111,
                   6'b011000, 14'h020, 32'h12345678, 32'hFFFF0000, 1'b0);
      tbl[11] = mk(4'b0001, 14'h000, 14'h000, 32'h0, ONES, 32'h99999999,  6'b000011, 14'h000, 32'h0, ONES, 1'b0);
      tbl[12] = mk(4'b1001, 14'h030, 14'h000, 32'h0, ONES, 32'h0,         6'b100001, 14'h030, 32'h0, ONES, 1'b0);
      tbl[13] = mk(4'b1111, 14'h031, 14'h050, 32'h0, ONES, 32'h77777777,  6'b010001, 14'h050, 32'h0, ONES, 1'b1);
      tbl[14] = mk(4'b1001, 14'h031, 14'h000, 32'h0, ONES, 32'hCAFEF00D,  6'b100101, 14'h031, 32'h0, ONES, 1'b0);
      tbl[15] = mk(4'b0011, 14'h000, 14'h060, 32'h0, ONES, 32'h22222222,  6'b011001, 14'h060, 32'h0, ONES, 1'b0);
      tbl[16] = mk(4'b1001, 14'h070, 14'h000, 32'h0, ONES, 32'h33333333,  6'b100101, 14'h070, 32'h0, ONES, 1'b0);
      tbl[17] = mk(4'b0001, 14'h000, 14'h000, 32'h0, ONES, 32'h44444444,  6'b001011, 14'h000, 32'h0, ONES, 1'b0);
      tbl[18] = mk(4'b1101, 14'h080, 14'h000, 32'h0, ONES, 32'h0,         6'b000011, 14'h000, 32'h0, ONES, 1'b1);
      tbl[19] = mk(4'b1001, 14'h080, 14'h000, 32'h0, ONES, 32'h0,         6'b100001, 14'h080, 32'h0, ONES, 1'b0);
      tbl[20] = mk(4'b0001, 14'h000, 14'h000, 32'h0, ONES, 32'h55555555,  6'b001011, 14'h000, 32'h0, ONES, 1'b0);

      #2;
      chk("rst if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("rst mem_ceb",   32'(mem_ceb),   32'd1);
      chk("rst stall",     32'(stall),     32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         if_req = tbl[i].rq[3]; if_flush = tbl[i].rq[2]; dm_req = tbl[i].rq[1]; dm_web = tbl[i].rq[0];
         if_addr = tbl[i].ia; dm_addr = tbl[i].da; dm_wdata = tbl[i].wd; dm_bweb = tbl[i].bw;
         mem_do = tbl[i].md;
         #2;
         chk($sformatf("v%0d if_gnt", i),    32'(if_gnt),    32'(tbl[i].ex[5]));
         chk($sformatf("v%0d dm_gnt", i),    32'(dm_gnt),    32'(tbl[i].ex[4]));
         chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].ex[3]));
         chk($sformatf("v%0d dm_rvalid", i), 32'(dm_rvalid), 32'(tbl[i].ex[2]));
         chk($sformatf("v%0d mem_ceb", i),   32'(mem_ceb),   32'(tbl[i].ex[1]));
         chk($sformatf("v%0d mem_web", i),   32'(mem_web),   32'(tbl[i].ex[0]));
         chk($sformatf("v%0d mem_a", i),     32'(mem_a),     32'(tbl[i].ea));
         chk($sformatf("v%0d mem_di", i),    mem_di,         tbl[i].edi);
         chk($sformatf("v%0d mem_bweb", i),  mem_bweb,       tbl[i].ebw);
         chk($sformatf("v%0d stall", i),     32'(stall),     32'(tbl[i].est));
         if (tbl[i].ex[3]) chk($sformatf("v%0d if_rdata", i), if_rdata, tbl[i].md);
         if (tbl[i].ex[2]) chk($sformatf("v%0d dm_rdata", i), dm_rdata, tbl[i].md);
      end

      // async reset in the middle of an IF response cycle
      @(negedge clk);
      drive(1'b1, 14'h090, 1'b0, 1'b0, 1'b1, 14'h000, 32'h0);
      #2 chk("ra if_gnt", 32'(if_gnt), 32'd1);
      @(negedge clk);
      drive(1'b0, 14'h000, 1'b0, 1'b0, 1'b1, 14'h000, 32'h66666666);
      #1 chk("ra if_rvalid before rst", 32'(if_rvalid), 32'd1);
      #1 rst = 1'b1;
      #1 chk("ra if_rvalid in rst", 32'(if_rvalid), 32'd0);
      chk("ra dm_rvalid in rst", 32'(dm_rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // fill the starve counter, then reset between edges: DM must win again
      for (int c = 0; c < 4; c++) begin
         if (c != 0) @(negedge clk);
         drive(1'b1, 14'h0A0, 1'b0, 1'b1, 1'b1, 14'h0B0, 32'h0);
         #2 chk($sformatf("rb c%0d dm_gnt", c), 32'(dm_gnt), 32'd1);
      end
      @(negedge clk);
      #1 chk("rb starved if_gnt", 32'(if_gnt), 32'd1);
      #1 rst = 1'b1;
      #1 chk("rb dm_rvalid in rst", 32'(dm_rvalid), 32'd0);
      rst = 1'b0;
      #1 chk("rb after rst dm_gnt", 32'(dm_gnt), 32'd1);
      chk("rb after rst if_gnt", 32'(if_gnt), 32'd0);
      chk("rb after rst stall", 32'(stall), 32'd1);
      @(negedge clk);
      drive(1'b1, 14'h0A0, 1'b0, 1'b0, 1'b1, 14'h000, 32'h0);
      #2 chk("rb tail if_gnt", 32'(if_gnt), 32'd1);
      chk("rb tail dm_rvalid", 32'(dm_rvalid), 32'd1);
      @(negedge clk);
      drive(1'b0, 14'h000, 1'b0, 1'b0, 1'b1, 14'h000, 32'h0);
      @(negedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
